// File: rtl/ccg_bist_engine.sv
// LFSR-driven self-test wrapper: stimulates a combinational CUT, compacts its responses in a MISR
// and compares the final signature. Define CCG_BIST_ABORT_EN to add the abort input.
module ccg_bist_engine #(
    parameter int              N_IN      = 7,
    parameter int              N_OUT     = 2,
    parameter int              SIG_W     = 16,
    parameter int              PAT_CNT   = 128,
    parameter logic [N_IN-1:0] LFSR_SEED = 7'h01,
    parameter logic [N_IN-1:0] TAP_MASK  = 7'h60,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CCG_BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_out,
    input  logic [SIG_W-1:0] exp_sig,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    localparam int CNT_W = $clog2(PAT_CNT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   cut_in_q, cut_in_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic              abort_req;

    function automatic logic [N_IN-1:0] lfsr_next(input logic [N_IN-1:0] v);
        return {v[N_IN-2:0], ^(v & TAP_MASK)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                   input logic [N_OUT-1:0] r);
        return {m[SIG_W-2:0], 1'b0} ^ (m[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(r);
    endfunction

`ifdef CCG_BIST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cut_in_q <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cut_in_q <= cut_in_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cut_in_d = cut_in_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cut_in_d = LFSR_SEED;
                    sig_d    = '0;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                end
            end
            S_RUN: begin
                // An abort freezes the partial signature instead of absorbing this cycle's response.
                if (abort_req) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    sig_d    = misr_step(sig_q, cut_out);
                    cut_in_d = lfsr_next(cut_in_q);
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PAT_CNT - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                pass_d  = (sig_q == exp_sig);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cut_in    = cut_in_q;
    assign signature = sig_q;
    assign pass      = pass_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/ccg_bist_engine.md
Name: ccg_bist_engine

Overview:
- Parametrised self-test wrapper for generated combinational benchmark circuits (N_IN inputs, N_OUT outputs).
- An LFSR drives the circuit-under-test (CUT) inputs. A MISR compacts the CUT outputs over PAT_CNT patterns.
- The final signature is compared against an expected value, giving a pass/fail result.
- Sits beside each generated CUT in the benchmark harness so circuit variants can be checked in hardware.

Parameters:
- N_IN, 7, CUT input width and LFSR width; legal range 2..32.
- N_OUT, 2, CUT output width; must be <= SIG_W.
- SIG_W, 16, MISR and signature width.
- PAT_CNT, 128, number of patterns applied per run; must be >= 1.
- LFSR_SEED, 7'h01, LFSR load value on start; must be nonzero.
- TAP_MASK, 7'h60, LFSR feedback taps. Default is x^7+x^6+1, which is maximal length.
- MISR_POLY, 16'h1021, MISR feedback polynomial.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- cut_in  out  N_IN  registered pattern driven to the CUT.
- cut_out  in  N_OUT  CUT response; combinational function of cut_in.
- exp_sig  in  SIG_W  expected signature; sampled in DONE.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse at the end of a run.
- signature  out  SIG_W  MISR contents; held after a run.
- pass  out  1  (signature == exp_sig), registered in DONE.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - cut_in, signature and pattern count = 0.
  - busy, done, pass = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at the clock edge: cut_in <= LFSR_SEED, signature <= 0, count <= 0, state -> RUN.
  - Otherwise all registers hold. start while busy or in DONE is ignored.
- RUN: busy=1. Each cycle:
  - signature <= step(signature, cut_out).
  - cut_in <= lfsr_next(cut_in).
  - count <= count+1.
  - When count == PAT_CNT-1, state -> DONE. Exactly PAT_CNT responses are absorbed, the first taken with cut_in = LFSR_SEED.
- lfsr_next(v): {v[N_IN-2:0], ^(v & TAP_MASK)}.
- step(m, r): {m[SIG_W-2:0], 1'b0} XOR (m[SIG_W-1] ? MISR_POLY : 0) XOR zero-extended r.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - pass <= (signature == exp_sig).
  - state -> IDLE.
- Held values: pass and signature hold until the next start. pass is cleared to 0 on start.
- Latency: start sampled at edge T gives busy=1 on cycles T+1..T+PAT_CNT and done=1 on cycle T+PAT_CNT+1.
- Boundaries:
  - PAT_CNT=1: a single RUN cycle.
  - Count width is $clog2(PAT_CNT+1); no wrap occurs.
  - Reset mid-run returns all outputs to reset values immediately. No done pulse is produced.
  - cut_in never becomes 0 during a run, because LFSR_SEED is nonzero and TAP_MASK is maximal.

Optional Feature:
- Macro CCG_BIST_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN forces state -> IDLE at the next edge: busy=0, done stays 0, pass=0, signature holds its partial value.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the final-pattern transition.
- When undefined: no abort port; runs always complete.

Test Plan:
1. Defaults, cut_out tied 2'b00, PAT_CNT=4, exp_sig=0, start pulse at T -> busy on T+1..T+4, done at T+5, signature=16'h0000, pass=1.
2. cut_out tied 2'b01, PAT_CNT=4 -> signature sequence 0001, 0003, 0007, 000F; final signature=16'h000F. exp_sig=16'h000F gives pass=1; exp_sig=16'h000E gives pass=0.
3. cut_out = cut_in[1:0] loopback -> cut_in sequence 01, 02, 04, 08, 10, 20, 41, 03 over the first 8 RUN cycles. MISR result matches the bench reference model.
4. rst asserted at RUN cycle 2 -> cut_in=0, signature=0, busy=0, no done pulse. A subsequent start runs a full, correct sequence.
5. start held high continuously -> back-to-back runs, with start re-sampled only in IDLE. One idle cycle between DONE and the next RUN; identical signatures each run.
6. With CCG_BIST_ABORT_EN, abort at RUN cycle 3 -> busy=0 next cycle, done never pulses, pass=0. The next start completes normally.
